// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared definitions for the decode->execute pipeline register.
//   REG_IDX_W : width of a register index (x0..x31)
//   alu_op_e  : ALU operation codes carried on alu_op
//   ctrl_t    : non-operand control fields held alongside the operands
package id_ex_pkg;

   localparam int REG_IDX_W = 5;

   // SRL/SRA and ADD/SUB are told apart by funct7, which travels beside alu_op.
   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SLL  = 3'd1,
      ALU_SLT  = 3'd2,
      ALU_SLTU = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_SRL  = 3'd5,
      ALU_OR   = 3'd6,
      ALU_AND  = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic [2:0]           alu_op;
      logic [6:0]           funct7;
      logic [4:0]           shamt;
      logic                 is_r_type;
      logic [REG_IDX_W-1:0] rd;
      logic                 reg_write;
      logic                 is_load;
   } ctrl_t;

endpackage

// File: rtl/id_ex_hazard.sv
// id_ex_hazard: combinational operand resolution for the two source registers
// of the instruction offered by decode.
//   rs1/rs2, rs1_used/rs2_used, rs1_data/rs2_data : sources and register-file read data
//   held_*      : instruction currently held in the stage (newest writer)
//   mem_fwd_*   : writer in EX/MEM; mem_fwd_pending means its value is not final yet
//   wb_fwd_*    : writer in MEM/WB (oldest writer still in flight)
//   operand1/2  : resolved source values
//   hazard      : decode must wait this cycle
// Build option: FORWARDING_EN. When defined, in-flight results are bypassed
// newest-first and only not-yet-available values stall. When undefined, operands
// come from the register file only and any in-flight writer of a used source stalls.
module id_ex_hazard
   import id_ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   input  logic                 rs1_used,
   input  logic                 rs2_used,
   input  logic [XLEN-1:0]      rs1_data,
   input  logic [XLEN-1:0]      rs2_data,
   input  logic                 held_valid,
   input  logic                 held_reg_write,
   input  logic                 held_is_load,
   input  logic [REG_IDX_W-1:0] held_rd,
   input  logic [XLEN-1:0]      alu_result,
   input  logic                 mem_fwd_en,
   input  logic [REG_IDX_W-1:0] mem_fwd_rd,
   input  logic [XLEN-1:0]      mem_fwd_data,
   input  logic                 mem_fwd_pending,
   input  logic                 wb_fwd_en,
   input  logic [REG_IDX_W-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0]      wb_fwd_data,
   output logic [XLEN-1:0]      operand1,
   output logic [XLEN-1:0]      operand2,
   output logic                 hazard
);

   for (genvar g = 0; g < 2; g++) begin : g_src
      logic [REG_IDX_W-1:0] rs;
      logic                 used;
      logic [XLEN-1:0]      rdata;
      logic [XLEN-1:0]      sel;
      logic                 live;
      logic                 held_hit;
      logic                 mem_hit;
      logic                 wb_hit;
      logic                 stall;

      assign rs    = (g == 0) ? rs1      : rs2;
      assign used  = (g == 0) ? rs1_used : rs2_used;
      assign rdata = (g == 0) ? rs1_data : rs2_data;

      // x0 is hard-wired zero: never matched, never forwarded, never stalls.
      assign live     = used && (rs != '0);
      assign held_hit = held_valid && held_reg_write && (held_rd == rs);
      assign mem_hit  = mem_fwd_en && (mem_fwd_rd == rs);
      assign wb_hit   = wb_fwd_en && (wb_fwd_rd == rs);

`ifdef FORWARDING_EN
      // Newest writer wins: held (in EX now) > EX/MEM > MEM/WB > register file.
      always_comb begin
         sel = rdata;
         if (rs == '0)     sel = '0;
         else if (!used)   sel = rdata;
         else if (held_hit) sel = alu_result;
         else if (mem_hit)  sel = mem_fwd_data;
         else if (wb_hit)   sel = wb_fwd_data;
      end

      // Only values that do not exist yet force a wait: a load still in EX,
      // or a load in EX/MEM whose data has not returned.
      assign stall = live && ((held_hit && held_is_load) || (mem_hit && mem_fwd_pending));
`else
      assign sel   = (rs == '0) ? '0 : rdata;
      assign stall = live && (held_hit || mem_hit || wb_hit);
`endif
   end

`ifndef FORWARDING_EN
   // Bypass inputs have no function in this build; fold them into a sink.
   logic unused_fwd;
   assign unused_fwd = ^{alu_result, mem_fwd_data, wb_fwd_data, held_is_load, mem_fwd_pending};
`endif

   assign operand1 = g_src[0].sel;
   assign operand2 = g_src[1].sel;
   assign hazard   = g_src[0].stall || g_src[1].stall;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register. Captures one decoded
// instruction, resolves its source operands at capture time (id_ex_hazard), and
// drives the ALU inputs straight from registers.
// Ports:
//   clk, rst (synchronous, active high), flush (kills held and incoming instruction)
//   in_valid/in_ready + in_* : instruction offered by decode
//   alu_result               : ALU output for the held instruction (bypass source)
//   mem_fwd_*, wb_fwd_*      : later-stage writers for bypass / hazard detection
//   out_valid/out_ready      : downstream handshake
//   out_pc, alu_in1, alu_in2, out_rs2_data, out_* control : held instruction
// Build option: FORWARDING_EN (see id_ex_hazard).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side. in_valid/out_valid never depend on the matching ready; the
// held instruction and all out_* fields stay stable while out_valid && !out_ready.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [REG_IDX_W-1:0] in_rs1,
   input  logic [REG_IDX_W-1:0] in_rs2,
   input  logic                 in_rs1_used,
   input  logic                 in_rs2_used,
   input  logic [XLEN-1:0]      in_rs1_data,
   input  logic [XLEN-1:0]      in_rs2_data,
   input  logic [XLEN-1:0]      in_imm,
   input  logic                 in_use_imm,
   input  logic [2:0]           in_alu_op,
   input  logic [6:0]           in_funct7,
   input  logic [4:0]           in_shamt,
   input  logic                 in_is_r_type,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic                 in_reg_write,
   input  logic                 in_is_load,
   input  logic [XLEN-1:0]      alu_result,
   input  logic                 mem_fwd_en,
   input  logic [REG_IDX_W-1:0] mem_fwd_rd,
   input  logic [XLEN-1:0]      mem_fwd_data,
   input  logic                 mem_fwd_pending,
   input  logic                 wb_fwd_en,
   input  logic [REG_IDX_W-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0]      wb_fwd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [XLEN-1:0]      alu_in1,
   output logic [XLEN-1:0]      alu_in2,
   output logic [XLEN-1:0]      out_rs2_data,
   output logic [2:0]           out_alu_op,
   output logic [6:0]           out_funct7,
   output logic [4:0]           out_shamt,
   output logic                 out_is_r_type,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic                 out_reg_write,
   output logic                 out_is_load
);

   logic            hazard;
   logic            capture;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   ctrl_t           held_ctrl;

   id_ex_hazard #(.XLEN(XLEN)) u_hazard (
      .rs1             (in_rs1),
      .rs2             (in_rs2),
      .rs1_used        (in_rs1_used),
      .rs2_used        (in_rs2_used),
      .rs1_data        (in_rs1_data),
      .rs2_data        (in_rs2_data),
      .held_valid      (out_valid),
      .held_reg_write  (held_ctrl.reg_write),
      .held_is_load    (held_ctrl.is_load),
      .held_rd         (held_ctrl.rd),
      .alu_result      (alu_result),
      .mem_fwd_en      (mem_fwd_en),
      .mem_fwd_rd      (mem_fwd_rd),
      .mem_fwd_data    (mem_fwd_data),
      .mem_fwd_pending (mem_fwd_pending),
      .wb_fwd_en       (wb_fwd_en),
      .wb_fwd_rd       (wb_fwd_rd),
      .wb_fwd_data     (wb_fwd_data),
      .operand1        (operand1),
      .operand2        (operand2),
      .hazard          (hazard)
   );

   // Accepting while the held instruction leaves the same cycle gives full throughput.
   assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
   assign capture  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         alu_in1      <= '0;
         alu_in2      <= '0;
         out_rs2_data <= '0;
         held_ctrl    <= '0;
      end else begin
         // in_ready is low during flush, so flush outranks capture here too.
         if (flush)          out_valid <= 1'b0;
         else if (capture)   out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;

         if (capture) begin
            out_pc       <= in_pc;
            alu_in1      <= operand1;
            alu_in2      <= in_use_imm ? in_imm : operand2;
            out_rs2_data <= operand2;  // store data is always the rs2 value
            held_ctrl    <= '{alu_op:    in_alu_op,
                              funct7:    in_funct7,
                              shamt:     in_shamt,
                              is_r_type: in_is_r_type,
                              rd:        in_rd,
                              reg_write: in_reg_write,
                              is_load:   in_is_load};
         end
      end
   end

   assign out_alu_op    = held_ctrl.alu_op;
   assign out_funct7    = held_ctrl.funct7;
   assign out_shamt     = held_ctrl.shamt;
   assign out_is_r_type = held_ctrl.is_r_type;
   assign out_rd        = held_ctrl.rd;
   assign out_reg_write = held_ctrl.reg_write;
   assign out_is_load   = held_ctrl.is_load;

endmodule
